// File: rtl/isqrt_inverse_checker.sv
// Reverse self-check for the rsqrt unit: p = x*y*y is compared against 1.0.
// Define CHK_ERR_MAX_EN to add the err_max peak-error output.
module isqrt_inverse_checker #(
    parameter int WL          = 24,
    parameter int DUT_LATENCY = 4,
    parameter int TOL         = 8,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             CE,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WL-1:0]    din,
    input  logic [WL-1:0]    y_in,
    output logic             chk_valid,
    output logic             chk_pass,
    output logic [WL-1:0]    err_mag,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
`ifdef CHK_ERR_MAX_EN
    output logic [WL-1:0]    err_max,
`endif
    output logic             sticky_fail
);

    localparam int EW = WL + 3;
    localparam logic [EW-1:0] ONE_Q =
        {{3{1'b0}}, 1'b1, {(WL-1){1'b0}}};
    localparam logic [WL-1:0] TOL_W = WL'(TOL);

    logic [WL-1:0]   x_dl [DUT_LATENCY];
    logic            v_dl [DUT_LATENCY];

    logic [WL:0]     s1_s;
    logic [WL-1:0]   s1_x;
    logic            s1_v;

    logic [WL+1:0]   s2_q;
    logic            s2_v;

    logic [2*WL-1:0] yy;
    logic [2*WL:0]   xs;
    logic [EW-1:0]   e;
    logic [EW-1:0]   e_abs;
    logic [WL-1:0]   mag_n;
    logic            pass_n;
    logic            unused_lsbs;

    // x and in_valid wait here until the rsqrt unit presents matching y
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DUT_LATENCY; i++) begin
                x_dl[i] <= '0;
                v_dl[i] <= 1'b0;
            end
        end else if (CE) begin
            x_dl[0] <= din;
            v_dl[0] <= in_valid;
            for (int i = 1; i < DUT_LATENCY; i++) begin
                x_dl[i] <= x_dl[i-1];
                v_dl[i] <= v_dl[i-1];
            end
        end
    end

    assign yy = {{WL{1'b0}}, y_in} * {{WL{1'b0}}, y_in};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            s1_s <= '0;
            s1_x <= '0;
            s1_v <= 1'b0;
        end else if (CE) begin
            s1_s <= yy[2*WL-1:WL-1];
            s1_x <= x_dl[DUT_LATENCY-1];
            s1_v <= v_dl[DUT_LATENCY-1];
        end
    end

    assign xs = {{(WL+1){1'b0}}, s1_x} * {{WL{1'b0}}, s1_s};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            s2_q <= '0;
            s2_v <= 1'b0;
        end else if (CE) begin
            s2_q <= xs[2*WL:WL-1];
            s2_v <= s1_v;
        end
    end

    assign unused_lsbs = ^{yy[WL-2:0], xs[WL-2:0]};

    // e is signed; its magnitude can exceed WL bits only for wild operands
    always_comb begin
        e      = {1'b0, s2_q} - ONE_Q;
        e_abs  = e[EW-1] ? (~e + EW'(1)) : e;
        mag_n  = (|e_abs[EW-1:WL]) ? '1 : e_abs[WL-1:0];
        pass_n = (mag_n <= TOL_W);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            chk_valid <= 1'b0;
            chk_pass  <= 1'b0;
            err_mag   <= '0;
        end else if (CE) begin
            chk_valid <= s2_v;
            if (s2_v) begin
                chk_pass <= pass_n;
                err_mag  <= mag_n;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sample_count <= '0;
            err_count    <= '0;
            sticky_fail  <= 1'b0;
        end else if (CE) begin
            if (clr) begin
                sample_count <= '0;
                err_count    <= '0;
                sticky_fail  <= 1'b0;
            end else if (s2_v) begin
                if (!(&sample_count))
                    sample_count <= sample_count + CNT_W'(1);
                if (!pass_n && !(&err_count))
                    err_count <= err_count + CNT_W'(1);
                if (!pass_n)
                    sticky_fail <= 1'b1;
            end
        end
    end

`ifdef CHK_ERR_MAX_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            err_max <= '0;
        end else if (CE) begin
            if (clr)
                err_max <= '0;
            else if (s2_v && (mag_n > err_max))
                err_max <= mag_n;
        end
    end
`endif

endmodule
